// File: rtl/regression_error_checker_pkg.sv
// Shared types and helpers for the linear-fit residual checker.
// State encoding plus a signed magnitude helper for the accumulator.
package regression_error_checker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int ABS_W = 64;

   // Callers sign-extend to ABS_W; the most negative DATA_W value maps to its true magnitude.
   function automatic logic [ABS_W-1:0] abs_signed(input logic [ABS_W-1:0] v);
      logic [ABS_W-1:0] r;
      if (v[ABS_W-1]) begin
         r = ~v + 64'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/regression_error_checker_sample_buffer.sv
// Sample store for the residual checker: one synchronous write port,
// one combinational read port, each row packed as {x, y}.
module regression_error_checker_sample_buffer
   import regression_error_checker_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 150,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_addr,
   input  logic [2*DATA_W-1:0] wr_data,
   input  logic [IDX_W-1:0]    rd_addr,
   output logic [2*DATA_W-1:0] rd_data
);

   logic [2*DATA_W-1:0] mem_q [DEPTH];

   // Contents are never reset; every row is rewritten before it is read in a run.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/regression_error_checker.sv
// Captures DEPTH (x, y) samples, streams residuals y - b_1*x - b_0 in load order
// and accumulates the sum of their magnitudes, pulsing done at the end of a run.
module regression_error_checker
   import regression_error_checker_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 150,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int ACC_W  = DATA_W + $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] b_0,
   input  logic [DATA_W-1:0] b_1,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x_Bus,
   input  logic [DATA_W-1:0] y_Bus,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] error,
   output logic [IDX_W-1:0]  err_index,
   output logic [ACC_W-1:0]  sum_abs_error,
   output logic              busy,
   output logic              done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   b0_q, b0_d, b1_q, b1_d;
   logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic [DATA_W-1:0]   error_q, error_d;
   logic [IDX_W-1:0]    err_index_q, err_index_d;
   logic [ACC_W-1:0]    sum_q, sum_d;

   logic [2*DATA_W-1:0] rd_data_s;
   logic [DATA_W-1:0]   rd_x_s, rd_y_s, prod_s, calc_err_s;
   logic [ABS_W-1:0]    err_ext_s;
   logic [ACC_W-1:0]    abs_err_s;
   logic                in_hs_s, out_hs_s;

   assign in_hs_s  = in_valid & in_ready_q;
   assign out_hs_s = out_valid_q & out_ready;

   regression_error_checker_sample_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_sample_buffer (
      .clk     (clk),
      .wr_en   (in_hs_s),
      .wr_addr (wr_ptr_q),
      .wr_data ({x_Bus, y_Bus}),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data_s)
   );

   // Residual of the sample at rd_ptr and magnitude of the result currently presented.
   always_comb begin
      rd_x_s     = rd_data_s[2*DATA_W-1:DATA_W];
      rd_y_s     = rd_data_s[DATA_W-1:0];
      prod_s     = b1_q * rd_x_s;
      calc_err_s = rd_y_s - prod_s - b0_q;
      err_ext_s  = {{(ABS_W - DATA_W){error_q[DATA_W-1]}}, error_q};
      abs_err_s  = ACC_W'(abs_signed(err_ext_s));
   end

   // Next-state, pointer, output-stage and accumulator logic.
   always_comb begin
      state_d     = state_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      sum_d       = sum_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d  = LOAD;
               b0_d     = b_0;
               b1_d     = b_1;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               sum_d    = '0;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (in_hs_s) begin
               wr_ptr_d = wr_ptr_q + IDX_W'(1);
               if (wr_ptr_q == LAST_IDX) begin
                  state_d = CALC;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         CALC: begin
            // The output register refills whenever it is empty or being drained.
            if (out_hs_s && (err_index_q == LAST_IDX)) begin
               sum_d       = sum_q + abs_err_s;
               out_valid_d = 1'b0;
               state_d     = DONE;
            end else if (out_hs_s || !out_valid_q) begin
               sum_d       = out_hs_s ? (sum_q + abs_err_s) : sum_q;
               out_valid_d = 1'b1;
               error_d     = calc_err_s;
               err_index_d = rd_ptr_q;
               rd_ptr_d    = rd_ptr_q + IDX_W'(1);
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d = (state_d == LOAD);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
   end

   // State and output registers; reset has priority over every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         b0_q        <= '0;
         b1_q        <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= '0;
         err_index_q <= '0;
         sum_q       <= '0;
      end else begin
         state_q     <= state_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         sum_q       <= sum_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_index     = err_index_q;
   assign sum_abs_error = sum_q;

endmodule

// File: tb/tb_regression_error_checker.sv
// Bench for regression_error_checker (DEPTH=4): directed and randomized runs checked
// against an arithmetic residual model.
module tb_regression_error_checker;

   localparam int DATA_W = 20;
   localparam int DEPTH  = 4;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int ACC_W  = DATA_W + $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic [DATA_W-1:0] b_0, b_1;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] x_Bus, y_Bus;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] error;
   logic [IDX_W-1:0]  err_index;
   logic [ACC_W-1:0]  sum_abs_error;
   logic              busy;
   logic              done;

   int tests = 0;
   int fails = 0;

   logic [DATA_W-1:0] xs [DEPTH];
   logic [DATA_W-1:0] ys [DEPTH];
   logic [DATA_W-1:0] exp_err [DEPTH];
   longint            exp_abs [DEPTH];
   longint            exp_sum;

   regression_error_checker #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .b_0           (b_0),
      .b_1           (b_1),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .x_Bus         (x_Bus),
      .y_Bus         (y_Bus),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .error         (error),
      .err_index     (err_index),
      .sum_abs_error (sum_abs_error),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Residual from the fit equation on sign-extended integers, reduced mod 2^DATA_W.
   function automatic logic [DATA_W-1:0] model_err(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                                   input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1);
      longint sx, sy, sb0, sb1, r;
      sx  = $signed(x);
      sy  = $signed(y);
      sb0 = $signed(b0);
      sb1 = $signed(b1);
      r   = sy - sb1 * sx - sb0;
      return DATA_W'(r);
   endfunction

   function automatic longint model_abs(input logic [DATA_W-1:0] e);
      longint v;
      v = $signed(e);
      return (v < 0) ? -v : v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // gap_mode: 0 continuous, 1 alternating, 2 random. bp_mode: 0 always ready, 1 stall 3 cycles at index 1, 2 random.
   task automatic run(input string name, input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                      input int gap_mode, input int bp_mode, input bit en_mid, input int abort_idx);
      int  k, cyc, idx, stall, w;
      bit  hs, aborted;
      longint part;
      exp_sum = 0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_err[i] = model_err(xs[i], ys[i], b0, b1);
         exp_abs[i] = model_abs(exp_err[i]);
         exp_sum += exp_abs[i];
      end
      w = 0;
      while (busy && w < 50) begin
         step();
         w++;
      end
      chk({name, "_idle_before_start"}, busy, 1'b0);

      b_0 = b0;
      b_1 = b1;
      en  = 1'b1;
      step();
      en  = 1'b0;
      b_0 = DATA_W'($urandom());
      b_1 = DATA_W'($urandom());
      chk({name, "_start_busy"}, busy, 1'b1);
      chk({name, "_start_sum_cleared"}, sum_abs_error, 0);

      k   = 0;
      cyc = 0;
      while (k < DEPTH && cyc < 200) begin
         chk($sformatf("%s_in_ready_load_%0d", name, k), in_ready, 1'b1);
         case (gap_mode)
            1:       in_valid = (cyc % 2 == 0);
            2:       in_valid = 1'($urandom_range(0, 1));
            default: in_valid = 1'b1;
         endcase
         x_Bus = xs[k];
         y_Bus = ys[k];
         if (en_mid && cyc == 1) begin
            en  = 1'b1;
            b_0 = 20'd100;
         end else begin
            en  = 1'b0;
         end
         hs = in_valid && in_ready;
         step();
         cyc++;
         if (hs) k++;
      end
      in_valid = 1'b0;
      en       = 1'b0;
      chk({name, "_load_count"}, k, DEPTH);
      chk({name, "_calc_in_ready_low"}, in_ready, 1'b0);
      chk({name, "_calc_first_cycle_no_valid"}, out_valid, 1'b0);
      out_ready = 1'b0;
      step();
      chk({name, "_first_valid_latency"}, out_valid, 1'b1);

      idx     = 0;
      cyc     = 0;
      stall   = 0;
      part    = 0;
      aborted = 1'b0;
      while (idx < DEPTH && cyc < 200) begin
         if (abort_idx == idx && out_valid) begin
            reset     = 1'b1;
            out_ready = 1'b0;
            step();
            reset   = 1'b0;
            aborted = 1'b1;
            break;
         end
         case (bp_mode)
            1: begin
               out_ready = !(idx == 1 && out_valid && stall < 3);
               if (!out_ready) stall++;
            end
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
         if (out_valid) begin
            chk($sformatf("%s_err[%0d]", name, idx), error, exp_err[idx]);
            chk($sformatf("%s_idx[%0d]", name, idx), err_index, idx);
         end
         chk($sformatf("%s_no_done_in_calc_%0d", name, cyc), done, 1'b0);
         hs = out_valid && out_ready;
         step();
         cyc++;
         if (hs) begin
            part += exp_abs[idx];
            idx++;
            chk($sformatf("%s_partial_sum_%0d", name, idx), sum_abs_error, part);
         end
      end
      out_ready = 1'b0;

      if (aborted) begin
         chk({name, "_rst_out_valid"}, out_valid, 1'b0);
         chk({name, "_rst_busy"}, busy, 1'b0);
         chk({name, "_rst_sum"}, sum_abs_error, 0);
         chk({name, "_rst_error"}, error, 0);
         chk({name, "_rst_index"}, err_index, 0);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_rst_no_done_%0d", name, i), done, 1'b0);
            step();
         end
      end else begin
         chk({name, "_result_count"}, idx, DEPTH);
         if (bp_mode == 1) chk({name, "_stall_cycles"}, stall, 3);
         chk({name, "_done_pulse"}, done, 1'b1);
         chk({name, "_done_out_valid_low"}, out_valid, 1'b0);
         chk({name, "_final_sum"}, sum_abs_error, exp_sum);
         step();
         chk({name, "_done_one_cycle"}, done, 1'b0);
         chk({name, "_back_to_idle"}, busy, 1'b0);
         chk({name, "_sum_held"}, sum_abs_error, exp_sum);
      end
   endtask

   initial begin
      reset     = 1'b1;
      en        = 1'b1;
      b_0       = '0;
      b_1       = '0;
      in_valid  = 1'b0;
      x_Bus     = '0;
      y_Bus     = '0;
      out_ready = 1'b0;
      step();
      chk("reset_wins_over_en", busy, 1'b0);
      en = 1'b0;
      step();
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_error", error, 0);
      chk("reset_index", err_index, 0);
      chk("reset_sum", sum_abs_error, 0);
      reset = 1'b0;
      step();

      xs = '{20'd1, 20'd2, 20'd3, 20'd4};
      ys = '{20'd5, 20'd7, 20'd9, 20'd20};
      run("basic", 20'd3, 20'd2, 0, 0, 1'b0, -1);
      chk("basic_sum_literal", sum_abs_error, 9);

      xs = '{20'd1, 20'd1, 20'd1, 20'd1};
      ys = '{20'd0, 20'd0, 20'd0, 20'd0};
      run("negative", 20'd3, 20'd2, 0, 0, 1'b0, -1);
      chk("negative_sum_literal", sum_abs_error, 20);

      xs = '{20'd1, 20'd2, 20'd3, 20'd4};
      ys = '{20'd5, 20'd7, 20'd9, 20'd20};
      run("backpressure", 20'd3, 20'd2, 0, 1, 1'b0, -1);
      run("gaps", 20'd3, 20'd2, 1, 0, 1'b0, -1);
      run("en_during_load", 20'd3, 20'd2, 0, 0, 1'b1, -1);
      run("reset_in_calc", 20'd3, 20'd2, 0, 0, 1'b0, 2);
      run("after_reset", 20'd3, 20'd2, 0, 0, 1'b0, -1);

      xs = '{20'h12345, 20'hFFFFF, 20'h00000, 20'h7FFFF};
      ys = '{20'h80000, 20'h80000, 20'h80000, 20'h80000};
      run("most_negative", 20'd0, 20'd0, 0, 0, 1'b0, -1);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            xs[i] = ($urandom_range(0, 3) == 0) ? 20'h80000 : DATA_W'($urandom());
            ys[i] = ($urandom_range(0, 3) == 0) ? 20'h7FFFF : DATA_W'($urandom());
         end
         run($sformatf("rand%0d", r), DATA_W'($urandom()), DATA_W'($urandom()), 2, 2, 1'b0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
